// File: rtl/seq_booth_divider.sv
// rtl/seq_booth_divider.sv - fixed-latency restoring divider, start/done handshake; DIV_SIGNED_EN enables two's complement operands
module seq_booth_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0] LAST = CW'(2*N-1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [2*N-1:0]   p_rem;
    logic [2*N-1:0]   dq;
    logic [N-1:0]     dvs_mag;
    logic             dv_zero;

    logic [2*N-1:0]   dd_mag_in;
    logic [N-1:0]     dv_mag_in;
    logic [2*N-1:0]   q_fix;
    logic [N-1:0]     r_fix;
    logic             ovf_fix;
    logic             q_bit;

    // Partial remainder stays below |divisor|, so upper bits of p_rem are zero
    // for any nonzero divisor and the full-width compare equals the N+1-bit one.
    assign q_bit = ({p_rem, dq[2*N-1]} >= (2*N+1)'(dvs_mag));

`ifdef DIV_SIGNED_EN
    logic sign_dd;
    logic sign_dv;

    assign dd_mag_in = dividend[2*N-1] ? -dividend : dividend;
    assign dv_mag_in = divisor[N-1] ? -divisor : divisor;
    assign q_fix     = (sign_dd ^ sign_dv) ? -dq : dq;
    assign r_fix     = sign_dd ? -p_rem[N-1:0] : p_rem[N-1:0];
    // Magnitude 2^(2N-1) with matching signs is the only unrepresentable quotient.
    assign ovf_fix   = ~(sign_dd ^ sign_dv) & dq[2*N-1];

    // Capture operand signs when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_dd <= 1'b0;
            sign_dv <= 1'b0;
        end else if (state == IDLE && start) begin
            sign_dd <= dividend[2*N-1];
            sign_dv <= divisor[N-1];
        end
    end
`else
    assign dd_mag_in = dividend;
    assign dv_mag_in = divisor;
    assign q_fix     = dq;
    assign r_fix     = p_rem[N-1:0];
    assign ovf_fix   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> CALC on start, 2N iterations, one FIX cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (count == LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift/subtract iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            p_rem       <= '0;
            dq          <= '0;
            dvs_mag     <= '0;
            dv_zero     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        dq      <= dd_mag_in;
                        dvs_mag <= dv_mag_in;
                        dv_zero <= (divisor == '0);
                        p_rem   <= '0;
                        count   <= '0;
                    end
                end
                CALC: begin
                    p_rem <= q_bit ? (2*N)'({p_rem, dq[2*N-1]} - (2*N+1)'(dvs_mag))
                                   : (2*N)'({p_rem, dq[2*N-1]});
                    dq    <= {dq[2*N-2:0], q_bit};
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (dv_zero) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_divider.sv
// tb/tb_seq_booth_divider.sv - self-checking bench for seq_booth_divider with an arithmetic reference model
module tb_seq_booth_divider;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_active = 0;
    int         m_cnt = 0;
    bit         m_done = 0;
    logic [7:0] m_q = '0;
    logic [3:0] m_r = '0;
    logic       m_z = 1'b0;
    logic       m_o = 1'b0;
    logic [7:0] p_q = '0;
    logic [3:0] p_r = '0;
    logic       p_z = 1'b0;
    logic       p_o = 1'b0;

    seq_booth_divider #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [7:0] a, input logic [3:0] b,
                                    output logic [7:0] q, output logic [3:0] r,
                                    output logic z, output logic o);
        int sa;
        int sb;
        z = 1'b0;
        o = 1'b0;
        if (b == 4'd0) begin
            q = '0;
            r = '0;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) begin
                q = 8'h80;
                r = '0;
                o = 1'b1;
            end else begin
                q = 8'(sa / sb);
                r = 4'(sa % sb);
            end
`else
            sa = int'(a);
            sb = int'(b);
            q = 8'(sa / sb);
            r = 4'(sa % sb);
`endif
        end
    endfunction

    // Timing model: accepted request completes 2N+1 edges later; busy in between.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_cnt = 0;
            m_done = 0;
            m_q = '0;
            m_r = '0;
            m_z = 1'b0;
            m_o = 1'b0;
        end else begin
            m_done = 0;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == 2*N+1) begin
                    m_active = 0;
                    m_done = 1;
                    m_q = p_q;
                    m_r = p_r;
                    m_z = p_z;
                    m_o = p_o;
                end
            end else if (start) begin
                m_active = 1;
                m_cnt = 0;
                ref_div(dividend, divisor, p_q, p_r, p_z, p_o);
            end
        end
    end

    // Compare every output against the model on each cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            check("div_by_zero", div_by_zero, m_z);
            check("overflow", overflow, m_o);
        end
    end

    task automatic wait_done(inout int lat);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string nm, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic ez, input logic eo);
        int lat;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        wait_done(lat);
        check({nm, " latency"}, lat, 9);
        check({nm, " q"}, quotient, eq);
        check({nm, " r"}, remainder, er);
        check({nm, " dbz"}, div_by_zero, ez);
        check({nm, " ovf"}, overflow, eo);
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        check("reset q", quotient, 0);
        check("reset r", remainder, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", div_by_zero, 0);
        check("reset ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef DIV_SIGNED_EN
        do_op("100/7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0);
        do_op("-100/7", 8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 1'b0);
        do_op("100/-8", 8'd100, 4'h8, 8'hF4, 4'd4, 1'b0, 1'b0);
        do_op("50/0", 8'd50, 4'd0, 8'd0, 4'd0, 1'b1, 1'b0);
        do_op("-128/-1", 8'h80, 4'hF, 8'h80, 4'd0, 1'b0, 1'b1);
`else
        do_op("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b0);
        do_op("255/15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 1'b0);
        do_op("50/0", 8'd50, 4'd0, 8'd0, 4'd0, 1'b1, 1'b0);
        do_op("128/15", 8'h80, 4'hF, 8'd8, 4'd8, 1'b0, 1'b0);
`endif

        // start while busy is ignored, operand changes while busy have no effect
        dividend = 8'd127;
        divisor = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        dividend = 8'd1;
        divisor = 4'd1;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        dividend = 8'hAA;
        divisor = 4'h5;
        wait_done(lat);
        check("busy-start latency", lat, 9);
        check("127/3 q", quotient, 42);
        check("127/3 r", remainder, 1);

        // restart in the done cycle is accepted
        do_op("6/2 in done cycle", 8'd6, 4'd2, 8'd3, 4'd0, 1'b0, 1'b0);

        // reset mid-operation aborts with no done pulse
        dividend = 8'd100;
        divisor = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort q", quotient, 0);
        check("abort r", remainder, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        lat = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) lat++;
        end
        check("no done after abort", lat, 0);
        do_op("20/3", 8'd20, 4'd3, 8'd6, 4'd2, 1'b0, 1'b0);

        // random requests, including starts while busy, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            dividend = 8'($urandom);
            divisor = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                dividend = 8'h80;
                divisor = 4'hF;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
